// File: rtl/image_frame_sequencer_pkg.sv
// Shared definitions for the image buffer, the frame sequencer and the engine:
// sequencer state encoding, default frame geometry and derived frame size.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int IMG_HEIGHT = 20;
  localparam int IMG_WIDTH  = 30;
  localparam int IMG_DEPTH  = 3;
  localparam int IMG_ADDR_W = 11;

  // Number of bytes in one frame (rows * columns * channels).
  function automatic int frame_bytes(input int h, input int w, input int d);
    return h * w * d;
  endfunction

  localparam int IMG_N = frame_bytes(IMG_HEIGHT, IMG_WIDTH, IMG_DEPTH);

endpackage

// File: rtl/image_frame_sequencer_read_port_arbiter.sv
// Combinational fixed-priority arbiter for the image buffer's single read port.
// The engine wins only while inference runs; debug is served whenever the
// engine is not using the port and no frame is being loaded.
module read_port_arbiter
  import image_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W
) (
  input  state_t            i_state,
  input  logic              i_eng_req,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic              i_dbg_req,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic              o_eng_gnt,
  output logic              o_dbg_gnt,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr
);

  // Grant selection by sequencer state, then read-port steering.
  always_comb begin
    o_eng_gnt = 1'b0;
    o_dbg_gnt = 1'b0;
    case (i_state)
      RUN: begin
        if (i_eng_req) begin
          o_eng_gnt = 1'b1;
        end else begin
          o_dbg_gnt = i_dbg_req;
        end
      end
      IDLE, DONE: begin
        o_dbg_gnt = i_dbg_req;
      end
      default: begin
        o_eng_gnt = 1'b0;
        o_dbg_gnt = 1'b0;
      end
    endcase
    o_rd_en = o_eng_gnt | o_dbg_gnt;
    if (o_eng_gnt) begin
      o_rd_addr = i_eng_addr;
    end else if (o_dbg_gnt) begin
      o_rd_addr = i_dbg_addr;
    end else begin
      o_rd_addr = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame sequencer: loads one RGB frame byte-by-byte into the image buffer,
// starts the inference engine when the frame is complete and shares the
// buffer read port between the engine and the debug/LED reader.
module image_frame_sequencer
  import image_pkg::*;
#(
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int WIDTH  = IMG_WIDTH,
  parameter int DEPTH  = IMG_DEPTH,
  parameter int ADDR_W = IMG_ADDR_W
) (
  input  logic              pi_clk,
  input  logic              rst,
  input  logic [7:0]        gpio_pin,
  input  logic              write_enable,
  input  logic              start_frame,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              frame_ready,
  output logic [1:0]        state,
  output logic              overflow
);

  localparam int N = frame_bytes(HEIGHT, WIDTH, DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] D_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ZERO     = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_h, r_w, r_d, r_count;
  logic [ADDR_W-1:0] w_h_nxt, w_w_nxt, w_d_nxt, w_count_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic              r_eng_start, w_eng_start_nxt;
  logic              r_frame_ready, w_frame_ready_nxt;
  logic              r_overflow, w_overflow_nxt;

  // Next-state, counter and registered-output computation.
  always_comb begin
    w_state_nxt       = r_state;
    w_h_nxt           = r_h;
    w_w_nxt           = r_w;
    w_d_nxt           = r_d;
    w_count_nxt       = r_count;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_eng_start_nxt   = 1'b0;
    w_frame_ready_nxt = r_frame_ready;
    w_overflow_nxt    = r_overflow;
    case (r_state)
      IDLE, DONE: begin
        if (start_frame) begin
          w_state_nxt       = LOAD;
          w_h_nxt           = ZERO;
          w_w_nxt           = ZERO;
          w_d_nxt           = ZERO;
          w_count_nxt       = ZERO;
          w_frame_ready_nxt = 1'b0;
          w_overflow_nxt    = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      LOAD: begin
        if (write_enable) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_count;
          w_wr_data_nxt = gpio_pin;
          if (r_count == LAST_IDX) begin
            // Final byte: hand the frame to the engine on the same edge.
            w_state_nxt       = RUN;
            w_frame_ready_nxt = 1'b1;
            w_eng_start_nxt   = 1'b1;
            w_h_nxt           = ZERO;
            w_w_nxt           = ZERO;
            w_d_nxt           = ZERO;
            w_count_nxt       = ZERO;
          end else begin
            w_count_nxt = r_count + ONE;
            if (r_d == D_LAST) begin
              w_d_nxt = ZERO;
              if (r_w == W_LAST) begin
                w_w_nxt = ZERO;
                w_h_nxt = r_h + ONE;
              end else begin
                w_w_nxt = r_w + ONE;
              end
            end else begin
              w_d_nxt = r_d + ONE;
            end
          end
        end else begin
          w_wr_en_nxt = 1'b0;
        end
      end
      RUN: begin
        if (eng_done) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // A byte strobe outside LOAD is lost; flag it until the next frame is armed.
    if (write_enable && (r_state != LOAD)) begin
      w_overflow_nxt = 1'b1;
    end else begin
      w_overflow_nxt = w_overflow_nxt;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge pi_clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_h           <= ZERO;
      r_w           <= ZERO;
      r_d           <= ZERO;
      r_count       <= ZERO;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= ZERO;
      r_wr_data     <= 8'd0;
      r_eng_start   <= 1'b0;
      r_frame_ready <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_h           <= w_h_nxt;
      r_w           <= w_w_nxt;
      r_d           <= w_d_nxt;
      r_count       <= w_count_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_eng_start   <= w_eng_start_nxt;
      r_frame_ready <= w_frame_ready_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign eng_start   = r_eng_start;
  assign frame_ready = r_frame_ready;
  assign overflow    = r_overflow;
  assign state       = r_state;

  read_port_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .i_state    (r_state),
    .i_eng_req  (eng_req),
    .i_eng_addr (eng_addr),
    .i_dbg_req  (dbg_req),
    .i_dbg_addr (dbg_addr),
    .o_eng_gnt  (eng_gnt),
    .o_dbg_gnt  (dbg_gnt),
    .o_rd_en    (mem_rd_en),
    .o_rd_addr  (mem_rd_addr)
  );

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Self-checking bench for image_frame_sequencer (2x3x3 frame = 18 bytes).
module tb_image_frame_sequencer;

  localparam int H  = 2;
  localparam int W  = 3;
  localparam int D  = 3;
  localparam int AW = 11;
  localparam int NB = H * W * D;

  logic          pi_clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    gpio_pin = 8'd0;
  logic          write_enable = 1'b0;
  logic          start_frame = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wr_data;
  logic          eng_start;
  logic          eng_done = 1'b0;
  logic          eng_req = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic          eng_gnt;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_gnt;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          frame_ready;
  logic [1:0]    state;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  image_frame_sequencer #(.HEIGHT(H), .WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .pi_clk(pi_clk), .rst(rst), .gpio_pin(gpio_pin), .write_enable(write_enable),
    .start_frame(start_frame), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .eng_start(eng_start), .eng_done(eng_done),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt), .dbg_req(dbg_req),
    .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .frame_ready(frame_ready), .state(state),
    .overflow(overflow)
  );

  always #5 pi_clk = ~pi_clk;

  // One rising edge, then settle so registered outputs are stable.
  task automatic tick();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if ({mem_wr_en, eng_start, frame_ready, overflow} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {mem_wr_en, eng_start, frame_ready, overflow}); end
    n_cmp++; if ({mem_wr_addr, mem_wr_data} !== '0) begin n_err++; $display("FAIL reset_wr got %0d/%0d want 0/0", mem_wr_addr, mem_wr_data); end
    n_cmp++; if ({eng_gnt, dbg_gnt, mem_rd_en, mem_rd_addr} !== '0) begin n_err++; $display("FAIL reset_rd got %b want 0", {eng_gnt, dbg_gnt, mem_rd_en, mem_rd_addr}); end
  endtask

  // Full frame load. Byte i must appear at address i one cycle after its strobe;
  // the last strobe also raises eng_start, frame_ready and RUN. Optional gap of
  // gap_len idle cycles after byte gap_after, optional random gaps/data.
  task automatic do_load(input int gap_after, input int gap_len, input bit rnd);
    logic [7:0] b;
    int gap;
    start_frame = 1'b1; tick(); start_frame = 1'b0;
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL load_enter state got %0d want 1", state); end
    n_cmp++; if ({frame_ready, overflow} !== 2'b00) begin n_err++; $display("FAIL load_enter flags got %b want 00", {frame_ready, overflow}); end
    for (int i = 0; i < NB; i++) begin
      gap = (i == gap_after + 1) ? gap_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gap; g++) begin
        eng_req = 1'($urandom); dbg_req = 1'($urandom);
        tick();
        n_cmp++; if ({mem_wr_en, eng_start, state} !== 4'b0001) begin n_err++; $display("FAIL load_gap got wr=%b st=%b state=%0d want 0 0 1", mem_wr_en, eng_start, state); end
        n_cmp++; if ({eng_gnt, dbg_gnt, mem_rd_en} !== 3'b000) begin n_err++; $display("FAIL load_grant got %b want 000", {eng_gnt, dbg_gnt, mem_rd_en}); end
      end
      eng_req = 1'b0; dbg_req = 1'b0;
      b = rnd ? 8'($urandom) : 8'(i);
      gpio_pin = b; write_enable = 1'b1; tick(); write_enable = 1'b0;
      n_cmp++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, AW'(i), b}) begin n_err++; $display("FAIL load_write got en=%b a=%0d d=%0d want 1 %0d %0d", mem_wr_en, mem_wr_addr, mem_wr_data, i, b); end
      if (i == NB - 1) begin
        n_cmp++; if ({eng_start, frame_ready, state} !== 4'b1110) begin n_err++; $display("FAIL load_done got st=%b fr=%b state=%0d want 1 1 2", eng_start, frame_ready, state); end
      end else begin
        n_cmp++; if ({eng_start, frame_ready, state} !== 4'b0001) begin n_err++; $display("FAIL load_mid got st=%b fr=%b state=%0d want 0 0 1", eng_start, frame_ready, state); end
      end
    end
    tick();
    n_cmp++; if ({mem_wr_en, eng_start, frame_ready, state} !== 5'b00110) begin n_err++; $display("FAIL load_after got %b want 00110", {mem_wr_en, eng_start, frame_ready, state}); end
  endtask

  task automatic test_overflow();
    write_enable = 1'b1; tick(); write_enable = 1'b0;
    n_cmp++; if ({mem_wr_en, overflow} !== 2'b01) begin n_err++; $display("FAIL ovf_set got wr=%b ovf=%b want 0 1", mem_wr_en, overflow); end
    repeat (3) tick();
    n_cmp++; if ({overflow, state} !== 3'b100) begin n_err++; $display("FAIL ovf_sticky got %b want 100", {overflow, state}); end
  endtask

  // Directed then random arbitration, expectations from the grant rules.
  task automatic test_arbitration(input logic [1:0] st);
    bit exp_e, exp_d;
    logic [AW-1:0] exp_a;
    eng_req = 1'b1; eng_addr = AW'(7); dbg_req = 1'b1; dbg_addr = AW'(3); #1;
    exp_e = (st == 2'd2);
    n_cmp++; if ({eng_gnt, dbg_gnt, mem_rd_en, mem_rd_addr} !== {exp_e, !exp_e, 1'b1, exp_e ? AW'(7) : AW'(3)}) begin n_err++; $display("FAIL arb_both got e=%b d=%b a=%0d st=%0d", eng_gnt, dbg_gnt, mem_rd_addr, st); end
    eng_req = 1'b0; #1;
    n_cmp++; if ({eng_gnt, dbg_gnt, mem_rd_addr} !== {1'b0, 1'b1, AW'(3)}) begin n_err++; $display("FAIL arb_dbg got e=%b d=%b a=%0d want 0 1 3", eng_gnt, dbg_gnt, mem_rd_addr); end
    for (int k = 0; k < 16; k++) begin
      eng_req = 1'($urandom); dbg_req = 1'($urandom);
      eng_addr = AW'($urandom); dbg_addr = AW'($urandom); #1;
      exp_e = eng_req && (st == 2'd2);
      exp_d = dbg_req && !exp_e && (st != 2'd1);
      exp_a = exp_e ? eng_addr : (exp_d ? dbg_addr : '0);
      n_cmp++; if ({eng_gnt, dbg_gnt, mem_rd_en, mem_rd_addr} !== {exp_e, exp_d, exp_e | exp_d, exp_a}) begin n_err++; $display("FAIL arb_rand got e=%b d=%b en=%b a=%0d want %b %b %0d", eng_gnt, dbg_gnt, mem_rd_en, mem_rd_addr, exp_e, exp_d, exp_a); end
    end
    eng_req = 1'b0; dbg_req = 1'b0; #1;
  endtask

  task automatic test_start_ignored_in_run();
    start_frame = 1'b1; tick(); start_frame = 1'b0;
    n_cmp++; if ({state, frame_ready} !== 3'b101) begin n_err++; $display("FAIL run_start_ign got %b want 101", {state, frame_ready}); end
  endtask

  task automatic test_done();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    n_cmp++; if ({state, frame_ready} !== 3'b111) begin n_err++; $display("FAIL done_enter got %b want 111", {state, frame_ready}); end
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    n_cmp++; if ({state, eng_start} !== 3'b110) begin n_err++; $display("FAIL done_hold got %b want 110", {state, eng_start}); end
  endtask

  task automatic test_reset_mid_load();
    start_frame = 1'b1; tick(); start_frame = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gpio_pin = 8'(i + 100); write_enable = 1'b1; tick(); write_enable = 1'b0;
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({state, mem_wr_en, eng_start, frame_ready, overflow, mem_wr_addr, mem_wr_data} !== '0) begin n_err++; $display("FAIL rst_mid got state=%0d wr=%b a=%0d d=%0d want all 0", state, mem_wr_en, mem_wr_addr, mem_wr_data); end
    repeat (2) tick();
    n_cmp++; if ({state, eng_start} !== 3'b000) begin n_err++; $display("FAIL rst_no_start got %b want 000", {state, eng_start}); end
    do_load(-2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arbitration(2'd0);
    test_overflow();
    do_load(-2, 0, 1'b0);
    test_arbitration(2'd2);
    test_start_ignored_in_run();
    test_done();
    test_arbitration(2'd3);
    do_load(4, 5, 1'b0);
    test_done();
    test_reset_mid_load();
    test_done();
    for (int r = 0; r < 3; r++) begin
      do_load(-2, 0, 1'b1);
      test_done();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_frame_sequencer.md
Name: image_frame_sequencer

Overview:
- Controls the on-chip RGB image buffer, which is loaded byte-by-byte from Raspberry Pi GPIO.
- Arms a frame load and generates linear write addresses from height/width/depth (h/w/d) counters.
- Starts the inference engine once the frame is complete.
- Shares the buffer's single read port between the inference engine and a debug/LED reader.
- Sits between the GPIO capture logic, the image memory, and the neural-net compute engine.

Parameters:
- HEIGHT, 20, image rows.
- WIDTH, 30, image columns.
- DEPTH, 3, colour channels per pixel (RGB).
- ADDR_W, 11, buffer address width; must satisfy 2**ADDR_W >= HEIGHT*WIDTH*DEPTH.

Ports:
- pi_clk  in  1  sole clock (Raspberry Pi clock).
- rst  in  1  reset; synchronous and active-high.
- gpio_pin  in  8  pixel byte from the Pi.
- write_enable  in  1  byte-valid strobe; one byte per high cycle.
- start_frame  in  1  single-cycle pulse that arms a new frame load.
- mem_wr_en  out  1  buffer write strobe.
- mem_wr_addr  out  ADDR_W  buffer write address.
- mem_wr_data  out  8  buffer write data.
- eng_start  out  1  single-cycle pulse that starts inference.
- eng_done  in  1  engine-finished pulse.
- eng_req  in  1  engine read request.
- eng_addr  in  ADDR_W  engine read address.
- eng_gnt  out  1  engine read grant.
- dbg_req  in  1  debug/LED read request.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_gnt  out  1  debug read grant.
- mem_rd_en  out  1  buffer read enable.
- mem_rd_addr  out  ADDR_W  buffer read address.
- frame_ready  out  1  high while a complete frame is held.
- state  out  2  FSM encoding, drives LEDs.
- overflow  out  1  sticky error: byte strobe arrived outside LOAD.

Behaviour:
- Define N = HEIGHT*WIDTH*DEPTH.
- FSM states: IDLE=0, LOAD=1, RUN=2, DONE=3.
- Reset (synchronous, pi_clk edge with rst=1):
  - state=IDLE; counters h/w/d and count cleared to 0.
  - All registered outputs 0: mem_wr_en, mem_wr_addr, mem_wr_data, eng_start, frame_ready, overflow.
  - A reset during LOAD or RUN aborts immediately; the partial frame is abandoned and no eng_start is issued.
- IDLE or DONE, start_frame=1:
  - Go to LOAD; clear counters, frame_ready and overflow.
- LOAD, write_enable=1:
  - Next cycle: mem_wr_en=1, mem_wr_addr=count, mem_wr_data=gpio_pin as sampled (write latency 1 cycle).
  - count increments.
  - d increments and wraps at DEPTH, carrying into w; w wraps at WIDTH, carrying into h.
  - Invariant: count == (h*WIDTH+w)*DEPTH+d.
- LOAD, write_enable=0: mem_wr_en=0 next cycle; counters hold. Gaps of any length are legal.
- Last byte (count==N-1 with write_enable=1):
  - That write is issued normally.
  - Same edge: state becomes RUN, frame_ready=1, eng_start=1 for exactly one cycle.
  - Counters return to 0.
- RUN, eng_done=1: state becomes DONE next cycle; frame_ready stays 1.
- start_frame is ignored in LOAD and RUN.
- eng_done is ignored outside RUN.
- write_enable outside LOAD: no memory write; overflow is set sticky.
- Read arbitration is combinational, with a zero-cycle grant:
  - LOAD: both grants 0; mem_rd_en=0.
  - RUN: engine has fixed priority. eng_req=1 gives eng_gnt=1 and mem_rd_addr=eng_addr. dbg_gnt=1 only when eng_req=0 and dbg_req=1.
  - IDLE and DONE: only debug is served; eng_gnt=0.
  - mem_rd_en = eng_gnt | dbg_gnt. With no grant, mem_rd_addr=0.
  - A requester that is not granted must hold its request; the sequencer does not queue.
- Addresses at or above N are never generated for writes. Read addresses pass through unchecked.

Decomposition:
- Package image_pkg holds:
  - The state enum (IDLE/LOAD/RUN/DONE).
  - HEIGHT/WIDTH/DEPTH defaults and the derived N constant, shared with the buffer and the engine.
- One sub-module, read_port_arbiter: the combinational 2-requester fixed-priority arbiter, with state as an input.
- The FSM and h/w/d counters stay in the top module.

Test Plan:
- Reset, then start_frame, then write_enable for 18 consecutive cycles (HEIGHT=2, WIDTH=3, DEPTH=3) with bytes 0..17 -> mem_wr_addr runs 0..17 with data 0..17, each one cycle after its strobe; exactly one eng_start pulse, on the cycle after byte 17; state=RUN; frame_ready=1.
- Same load with a 5-cycle write_enable gap after byte 4 -> no writes during the gap; byte 5 lands at address 5; completion timing is unchanged relative to the last strobe.
- In RUN, eng_req=1 (addr 7) and dbg_req=1 (addr 3) together -> eng_gnt=1, dbg_gnt=0, mem_rd_addr=7. Drop eng_req -> dbg_gnt=1, mem_rd_addr=3.
- In IDLE, write_enable=1 for 1 cycle -> mem_wr_en stays 0, overflow=1 and stays high. A following start_frame clears it.
- rst asserted after byte 9 of the load -> next cycle state=IDLE and all outputs 0. A new start_frame plus 18 bytes starts again at address 0.
- eng_done in RUN -> DONE, frame_ready=1. In DONE: dbg_req is granted, eng_req is not. A start_frame in DONE returns to LOAD with frame_ready=0.
